ws2812_encoder: RTL and testbench



---
 rtl/ws2812_encoder_if.sv | 26 ++
 rtl/ws2812_encoder.sv | 185 ++++++++++++++++++
 tb/tb_ws2812_encoder.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/ws2812_encoder_if.sv
// Pixel stream interface for the WS2812 encoder.
//   pixel_data_in   : 24-bit GRB word, bit 23 transmitted first
//   pixel_valid_in  : pixel_data_in holds a word
//   pixel_ready_out : encoder can take a word this cycle
//   frame_end_in    : one-cycle pulse requesting a strip latch after queued pixels
// master = pixel source, slave = encoder.
interface ws2812_encoder_if;
    logic [23:0] pixel_data_in;
    logic        pixel_valid_in;
    logic        pixel_ready_out;
    logic        frame_end_in;

    modport master (
        output pixel_data_in,
        output pixel_valid_in,
        output frame_end_in,
        input  pixel_ready_out
    );

    modport slave (
        input  pixel_data_in,
        input  pixel_valid_in,
        input  frame_end_in,
        output pixel_ready_out
    );
endinterface

// File: rtl/ws2812_encoder.sv
// Single-wire NRZ encoder for WS2812-class LED strings.
// Ports:
//   clk_in   : system clock
//   rst_in   : synchronous reset, active-high
//   pix      : pixel stream (slave side of ws2812_encoder_if)
//   bit_out  : registered serial line to the strip
//   busy_out : registered, high while any pixel or latch work is outstanding
// One pixel shifts out while a second waits in a holding buffer, so a source can
// keep the line continuously busy. bit_out and busy_out are registered from the
// current state, so the line trails the internal state by one cycle.
module ws2812_encoder #(
    parameter int unsigned T0H     = 80,
    parameter int unsigned T1H     = 160,
    parameter int unsigned T_BIT   = 250,
    parameter int unsigned RST_CNT = 60000
) (
    input  logic              clk_in,
    input  logic              rst_in,
    ws2812_encoder_if.slave   pix,
    output logic              bit_out,
    output logic              busy_out
);

    localparam int unsigned CntW  = $clog2(T_BIT);
    localparam int unsigned LcntW = $clog2(RST_CNT + 1);

    localparam logic [CntW-1:0]  CntLast  = CntW'(T_BIT - 1);
    localparam logic [CntW-1:0]  HiOne    = CntW'(T1H);
    localparam logic [CntW-1:0]  HiZero   = CntW'(T0H);
    localparam logic [LcntW-1:0] LcntLast = LcntW'(RST_CNT - 1);

    typedef enum logic [1:0] {StIdle, StSend, StLatch} state_e;

    state_e            state_q, state_d;
    logic [23:0]       sh_q, sh_d;
    logic [23:0]       buf_q, buf_d;
    logic              sh_full_q, sh_full_d;
    logic              buf_full_q, buf_full_d;
    logic              flag_q, flag_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [4:0]        idx_q, idx_d;
    logic [LcntW-1:0]  lcnt_q, lcnt_d;
    logic              bit_q, bit_d;
    logic              busy_q, busy_d;

    logic accept, direct, last_bit, latch_done, flag_now;

    // Ready depends only on registered state (and reset), never on valid.
    assign pix.pixel_ready_out = !buf_full_q && !rst_in;

    assign accept     = pix.pixel_valid_in && pix.pixel_ready_out;
    assign direct     = accept && (state_q == StIdle) && !sh_full_q;
    assign last_bit   = (cnt_q == CntLast) && (idx_q == 5'd0);
    assign latch_done = (lcnt_q == LcntLast);
    // A frame end arriving on the final bit cycle still latches without an extra idle cycle.
    assign flag_now   = flag_q || pix.frame_end_in;

    always_ff @(posedge clk_in) begin
        if (rst_in) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (direct || buf_full_q) state_d = StSend;
                else if (flag_q)          state_d = StLatch;
            end
            StSend: begin
                if (last_bit && !buf_full_q) state_d = flag_now ? StLatch : StIdle;
            end
            StLatch: begin
                if (latch_done) state_d = buf_full_q ? StSend : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bit_d  = (state_q == StSend) && (cnt_q < (sh_q[23] ? HiOne : HiZero));
        busy_d = (state_q != StIdle) || sh_full_q || buf_full_q || flag_q;
    end

    always_comb begin
        sh_d       = sh_q;
        buf_d      = buf_q;
        sh_full_d  = sh_full_q;
        buf_full_d = buf_full_q;
        flag_d     = flag_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        lcnt_d     = lcnt_q;

        // Frame ends during a running latch are dropped; repeats before it merge.
        if (pix.frame_end_in && (state_q != StLatch)) flag_d = 1'b1;

        if (direct) begin
            sh_d      = pix.pixel_data_in;
            sh_full_d = 1'b1;
            cnt_d     = '0;
            idx_d     = 5'd23;
        end else if (accept) begin
            buf_d      = pix.pixel_data_in;
            buf_full_d = 1'b1;
        end

        // Buffer-to-shifter moves only happen while buffer is full, i.e. ready is low,
        // so they never collide with an accept above.
        unique case (state_q)
            StIdle: begin
                if (!direct && buf_full_q) begin
                    sh_d       = buf_q;
                    sh_full_d  = 1'b1;
                    buf_full_d = 1'b0;
                    cnt_d      = '0;
                    idx_d      = 5'd23;
                end
            end
            StSend: begin
                if (cnt_q == CntLast) begin
                    cnt_d = '0;
                    if (idx_q != 5'd0) begin
                        idx_d = idx_q - 5'd1;
                        sh_d  = {sh_q[22:0], 1'b0};
                    end else if (buf_full_q) begin
                        sh_d       = buf_q;
                        buf_full_d = 1'b0;
                        idx_d      = 5'd23;
                    end else begin
                        sh_full_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StLatch: begin
                if (latch_done) begin
                    lcnt_d = '0;
                    flag_d = 1'b0;
                    if (buf_full_q) begin
                        sh_d       = buf_q;
                        sh_full_d  = 1'b1;
                        buf_full_d = 1'b0;
                        cnt_d      = '0;
                        idx_d      = 5'd23;
                    end
                end else begin
                    lcnt_d = lcnt_q + LcntW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sh_q       <= '0;
            buf_q      <= '0;
            sh_full_q  <= 1'b0;
            buf_full_q <= 1'b0;
            flag_q     <= 1'b0;
            cnt_q      <= '0;
            idx_q      <= '0;
            lcnt_q     <= '0;
            bit_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            sh_q       <= sh_d;
            buf_q      <= buf_d;
            sh_full_q  <= sh_full_d;
            buf_full_q <= buf_full_d;
            flag_q     <= flag_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            lcnt_q     <= lcnt_d;
            bit_q      <= bit_d;
            busy_q     <= busy_d;
        end
    end

    assign bit_out  = bit_q;
    assign busy_out = busy_q;

endmodule

// File: tb/tb_ws2812_encoder.sv
// Directed bench for ws2812_encoder with T0H=2, T1H=5, T_BIT=8, RST_CNT=20.
// Waveform index k is the sample taken 1 time unit after clock edge k of a stream;
// edge 0 is the edge that accepts the first word, so transmission occupies k=1..192.
module tb_ws2812_encoder;

    logic clk;
    logic rst;
    logic bit_line;
    logic busy;

    ws2812_encoder_if bus ();

    ws2812_encoder #(
        .T0H     (2),
        .T1H     (5),
        .T_BIT   (8),
        .RST_CNT (20)
    ) dut (
        .clk_in   (clk),
        .rst_in   (rst),
        .pix      (bus),
        .bit_out  (bit_line),
        .busy_out (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        wf [0:1023];
    logic        rd [0:1023];
    logic        bz [0:1023];
    logic [23:0] words [0:3];
    int          offer_at [0:3];
    int          acc_k [0:3];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives words[0..nw-1]; word i>0 is offered from sample offer_at[i] onward.
    task automatic stream(input int nw, input int ncyc, input logic fe_first);
        int  idx;
        logic xfer;
        idx = 0;
        for (int i = 0; i < 4; i++) acc_k[i] = -1;
        bus.pixel_data_in  = words[0];
        bus.pixel_valid_in = 1'b1;
        bus.frame_end_in   = fe_first;
        for (int k = 0; k < ncyc; k++) begin
            xfer = bus.pixel_valid_in && bus.pixel_ready_out;
            step();
            bus.frame_end_in = 1'b0;
            if (xfer) begin
                acc_k[idx] = k;
                idx++;
            end
            wf[k] = bit_line;
            rd[k] = bus.pixel_ready_out;
            bz[k] = busy;
            if (idx < nw && k >= offer_at[idx]) begin
                bus.pixel_valid_in = 1'b1;
                bus.pixel_data_in  = words[idx];
            end else begin
                bus.pixel_valid_in = 1'b0;
            end
        end
        bus.pixel_valid_in = 1'b0;
    endtask

    // Each bit slot is 8 samples; high for the first 5 ('1') or 2 ('0') of them.
    task automatic check_pix(input logic [23:0] word, input int start, input string name);
        logic [7:0] obs;
        logic [7:0] exp;
        int th;
        for (int b = 0; b < 24; b++) begin
            th = word[23-b] ? 5 : 2;
            for (int c = 0; c < 8; c++) begin
                exp[c] = (c < th);
                obs[c] = wf[start + b*8 + c];
            end
            check($sformatf("%s_bit%0d", name, 23 - b), {24'd0, obs}, {24'd0, exp});
        end
    endtask

    task automatic check_low(input int start, input int n, input string name);
        int highs;
        highs = 0;
        for (int k = start; k < start + n; k++) if (wf[k] !== 1'b0) highs++;
        check(name, highs, 0);
    endtask

    initial begin
        int cnt;
        rst = 1'b1;
        bus.pixel_data_in  = '0;
        bus.pixel_valid_in = 1'b0;
        bus.frame_end_in   = 1'b0;
        for (int i = 0; i < 4; i++) offer_at[i] = 0;

        // Reset
        step(); step(); step();
        check("rst_ready", bus.pixel_ready_out, 0);
        check("rst_bit", bit_line, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        step();
        check("rel_ready", bus.pixel_ready_out, 1);
        check("rel_bit", bit_line, 0);
        check("rel_busy", busy, 0);

        // Single pixel 0xA50000
        words[0] = 24'hA50000;
        stream(1, 196, 1'b0);
        check("t1_acc", acc_k[0], 0);
        check("t1_pre", wf[0], 0);
        check_pix(24'hA50000, 1, "t1");
        check_low(193, 3, "t1_after");
        check("t1_busy_last", bz[192], 1);
        check("t1_busy_off", bz[193], 0);

        // Back-to-back with valid held high
        words[0] = 24'hFFFFFF; words[1] = 24'h000000; words[2] = 24'h800001;
        offer_at[1] = 0; offer_at[2] = 0;
        stream(3, 580, 1'b0);
        check("t2_acc1", acc_k[1], 1);
        check("t2_rdy_full", rd[1], 0);
        check("t2_rdy_hold", rd[191], 0);
        check("t2_rdy_free", rd[192], 1);
        check("t2_acc2", acc_k[2], 193);
        check("t2_rdy_refull", rd[193], 0);
        check_pix(24'hFFFFFF, 1, "t2p0");
        check_pix(24'h000000, 193, "t2p1");
        check_pix(24'h800001, 385, "t2p2");
        check_low(577, 3, "t2_after");
        check("t2_busy_off", bz[578], 0);

        // Pixel with frame_end in the same cycle
        words[0] = 24'h000001;
        stream(1, 220, 1'b1);
        check_pix(24'h000001, 1, "t3");
        check_low(193, 27, "t3_latch");
        check("t3_busy_latch_end", bz[212], 1);
        check("t3_busy_off", bz[213], 0);

        // Pixel offered during the latch
        words[0] = 24'h000001; words[1] = 24'h5A0000;
        offer_at[1] = 200;
        stream(2, 408, 1'b1);
        check("t4_acc", acc_k[1], 201);
        check("t4_rdy_full", rd[201], 0);
        check("t4_rdy_hold", rd[211], 0);
        check("t4_rdy_free", rd[212], 1);
        check_low(193, 20, "t4_latch");
        check_pix(24'h5A0000, 213, "t4p1");
        check_low(405, 3, "t4_after");
        check("t4_idle_busy", busy, 0);

        // Three frame_end pulses with no pixels
        for (int k = 0; k < 40; k++) begin
            bus.frame_end_in = (k < 3);
            step();
            bz[k] = busy;
            wf[k] = bit_line;
        end
        bus.frame_end_in = 1'b0;
        cnt = 0;
        for (int k = 0; k < 40; k++) if (bz[k] === 1'b1) cnt++;
        check("t5_busy_cycles", cnt, 21);
        check("t5_busy_start", bz[1], 1);
        check("t5_busy_end", bz[21], 1);
        check("t5_busy_off", bz[22], 0);
        check_low(0, 40, "t5_line");

        // Reset during bit 10, cnt 3, with a buffered pixel
        words[0] = 24'hFFFFFF; words[1] = 24'h123456;
        offer_at[1] = 0;
        stream(2, 108, 1'b0);
        check("t6_buffered", acc_k[1], 1);
        check("t6_high_before", wf[107], 1);
        rst = 1'b1;
        check("t6_rdy_in_rst", bus.pixel_ready_out, 0);
        step();
        check("t6_bit_abort", bit_line, 0);
        check("t6_rdy_rst", bus.pixel_ready_out, 0);
        step();
        rst = 1'b0;
        step();
        check("t6_rdy_rel", bus.pixel_ready_out, 1);
        check("t6_busy_rel", busy, 0);
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (bit_line !== 1'b0 || busy !== 1'b0) cnt++;
        end
        check("t6_discarded", cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
